// File: rtl/mvu_pkg.sv
// Shared definitions for the MVU data-bank port arbiter.
// Provides the requester indices (datapath D, interconnect I and controller C)
// and the one-hot request/grant vector type indexed by those constants.
package mvu_pkg;

  localparam int REQ_D = 0;
  localparam int REQ_I = 1;
  localparam int REQ_C = 2;
  localparam int NREQ  = 3;

  // One bit per requester, indexed by REQ_D/REQ_I/REQ_C.
  typedef logic [NREQ-1:0] req_vec_t;

endpackage

// File: rtl/prio_starve_arb.sv
// Three-way fixed-priority arbiter (D > I > C) with starvation override.
// I and C each own a saturating wait counter. Once a counter reaches MAXWAIT,
// that requester preempts D. When both are starved, I goes first and C's
// counter holds at MAXWAIT, so C wins on the following cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_en     : request vector (one bit per requester)
//   grnt       : one-hot grant, combinational from req_en and the counters
module prio_starve_arb
  import mvu_pkg::*;
#(
  parameter int MAXWAIT = 15,
  parameter int BWAIT   = $clog2(MAXWAIT + 1)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req_en,
  output req_vec_t grnt
);

  localparam logic [BWAIT-1:0] MAXW = BWAIT'(MAXWAIT);

  // D never starves; only the I and C bits are driven from counters.
  logic [NREQ-1:0] starved;
  assign starved[REQ_D] = 1'b0;

  // Grants are held low while reset is asserted so the bank sees no access.
  always_comb begin
    grnt = '0;
    if (rst_n) begin
      if (req_en[REQ_I] && starved[REQ_I]) begin
        grnt[REQ_I] = 1'b1;
      end else if (req_en[REQ_C] && starved[REQ_C]) begin
        grnt[REQ_C] = 1'b1;
      end else if (req_en[REQ_D]) begin
        grnt[REQ_D] = 1'b1;
      end else if (req_en[REQ_I]) begin
        grnt[REQ_I] = 1'b1;
      end else if (req_en[REQ_C]) begin
        grnt[REQ_C] = 1'b1;
      end
    end
  end

  for (genvar gi = REQ_I; gi <= REQ_C; gi++) begin : g_wait
    logic [BWAIT-1:0] wait_q;
    logic [BWAIT-1:0] wait_d;

    assign starved[gi] = (wait_q == MAXW);

    // Count consecutive denied cycles; any idle or granted cycle restarts it.
    always_comb begin
      wait_d = wait_q;
      if (!req_en[gi] || grnt[gi]) begin
        wait_d = '0;
      end else if (wait_q != MAXW) begin
        wait_d = wait_q + BWAIT'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_d;
      end
    end
  end

endmodule

// File: rtl/dbank_port_arbiter.sv
// Shares one data-bank read port and one write port among the datapath/AGU (D),
// interconnect (I) and controller (C) of an MVU.
// Read and write sides are arbitrated independently. A one-hot tag of each read
// grant travels down an RDLAT-deep pipeline so the matching *_vld strobe rises
// when bank_rd_word carries that requester's data.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   rd{d,i,c}_en/_addr       : read requests; rd*_grnt same-cycle grants
//   rd{d,i,c}_vld            : read data valid, RDLAT cycles after the grant
//   wr{d,i,c}_en/_addr/_word : write requests; wr*_grnt same-cycle grants
//   bank_rd_*/bank_wr_*      : muxed bank port (zero when nothing granted)
module dbank_port_arbiter
  import mvu_pkg::*;
#(
  parameter int BDBANKA = 15,
  parameter int BDBANKW = 64,
  parameter int RDLAT   = 2,
  parameter int MAXWAIT = 15,
  localparam int BWAIT  = $clog2(MAXWAIT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdd_en,
  input  logic               rdi_en,
  input  logic               rdc_en,
  input  logic [BDBANKA-1:0] rdd_addr,
  input  logic [BDBANKA-1:0] rdi_addr,
  input  logic [BDBANKA-1:0] rdc_addr,
  output logic               rdd_grnt,
  output logic               rdi_grnt,
  output logic               rdc_grnt,
  output logic               rdd_vld,
  output logic               rdi_vld,
  output logic               rdc_vld,
  input  logic               wrd_en,
  input  logic               wri_en,
  input  logic               wrc_en,
  input  logic [BDBANKA-1:0] wrd_addr,
  input  logic [BDBANKA-1:0] wri_addr,
  input  logic [BDBANKA-1:0] wrc_addr,
  input  logic [BDBANKW-1:0] wrd_word,
  input  logic [BDBANKW-1:0] wri_word,
  input  logic [BDBANKW-1:0] wrc_word,
  output logic               wrd_grnt,
  output logic               wri_grnt,
  output logic               wrc_grnt,
  output logic               bank_rd_en,
  output logic [BDBANKA-1:0] bank_rd_addr,
  output logic               bank_wr_en,
  output logic [BDBANKA-1:0] bank_wr_addr,
  output logic [BDBANKW-1:0] bank_wr_word
);

  req_vec_t rd_en_v, rd_grnt_v;
  req_vec_t wr_en_v, wr_grnt_v;

  logic [BDBANKA-1:0] rd_addr_a [NREQ];
  logic [BDBANKA-1:0] wr_addr_a [NREQ];
  logic [BDBANKW-1:0] wr_word_a [NREQ];

  assign rd_en_v = {rdc_en, rdi_en, rdd_en};
  assign wr_en_v = {wrc_en, wri_en, wrd_en};

  assign rd_addr_a[REQ_D] = rdd_addr;
  assign rd_addr_a[REQ_I] = rdi_addr;
  assign rd_addr_a[REQ_C] = rdc_addr;
  assign wr_addr_a[REQ_D] = wrd_addr;
  assign wr_addr_a[REQ_I] = wri_addr;
  assign wr_addr_a[REQ_C] = wrc_addr;
  assign wr_word_a[REQ_D] = wrd_word;
  assign wr_word_a[REQ_I] = wri_word;
  assign wr_word_a[REQ_C] = wrc_word;

  prio_starve_arb #(.MAXWAIT(MAXWAIT), .BWAIT(BWAIT)) u_rd_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_en (rd_en_v),
    .grnt   (rd_grnt_v)
  );

  prio_starve_arb #(.MAXWAIT(MAXWAIT), .BWAIT(BWAIT)) u_wr_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_en (wr_en_v),
    .grnt   (wr_grnt_v)
  );

  assign {rdc_grnt, rdi_grnt, rdd_grnt} = rd_grnt_v;
  assign {wrc_grnt, wri_grnt, wrd_grnt} = wr_grnt_v;

  // Grants are one-hot, so selecting the single granted entry is a plain mux;
  // with no grant the outputs stay at zero.
  always_comb begin
    bank_rd_en   = |rd_grnt_v;
    bank_wr_en   = |wr_grnt_v;
    bank_rd_addr = '0;
    bank_wr_addr = '0;
    bank_wr_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_grnt_v[i]) begin
        bank_rd_addr = rd_addr_a[i];
      end
      if (wr_grnt_v[i]) begin
        bank_wr_addr = wr_addr_a[i];
        bank_wr_word = wr_word_a[i];
      end
    end
  end

  // Read-return tag pipeline: stage 0 captures the grant, and the last stage
  // lines up with the bank's read data RDLAT cycles later.
  req_vec_t tag_q [RDLAT];
  req_vec_t tag_d [RDLAT];

  always_comb begin
    tag_d[0] = rd_grnt_v;
    for (int i = 1; i < RDLAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '{default: '0};
    end else begin
      tag_q <= tag_d;
    end
  end

  assign {rdc_vld, rdi_vld, rdd_vld} = tag_q[RDLAT-1];

endmodule

// File: tb/tb_dbank_port_arbiter.sv
// Self-checking bench for dbank_port_arbiter: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against a
// behavioural model (wait counts as integers, a queue of pending read tags).
module tb_dbank_port_arbiter;

  localparam int A       = 15;
  localparam int W       = 64;
  localparam int RDLAT   = 2;
  localparam int MAXWAIT = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rdd_en, rdi_en, rdc_en;
  logic [A-1:0] rdd_addr, rdi_addr, rdc_addr;
  logic         rdd_grnt, rdi_grnt, rdc_grnt;
  logic         rdd_vld, rdi_vld, rdc_vld;
  logic         wrd_en, wri_en, wrc_en;
  logic [A-1:0] wrd_addr, wri_addr, wrc_addr;
  logic [W-1:0] wrd_word, wri_word, wrc_word;
  logic         wrd_grnt, wri_grnt, wrc_grnt;
  logic         bank_rd_en, bank_wr_en;
  logic [A-1:0] bank_rd_addr, bank_wr_addr;
  logic [W-1:0] bank_wr_word;

  always #5 clk = ~clk;

  dbank_port_arbiter #(.BDBANKA(A), .BDBANKW(W), .RDLAT(RDLAT), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rdd_en(rdd_en), .rdi_en(rdi_en), .rdc_en(rdc_en),
    .rdd_addr(rdd_addr), .rdi_addr(rdi_addr), .rdc_addr(rdc_addr),
    .rdd_grnt(rdd_grnt), .rdi_grnt(rdi_grnt), .rdc_grnt(rdc_grnt),
    .rdd_vld(rdd_vld), .rdi_vld(rdi_vld), .rdc_vld(rdc_vld),
    .wrd_en(wrd_en), .wri_en(wri_en), .wrc_en(wrc_en),
    .wrd_addr(wrd_addr), .wri_addr(wri_addr), .wrc_addr(wrc_addr),
    .wrd_word(wrd_word), .wri_word(wri_word), .wrc_word(wrc_word),
    .wrd_grnt(wrd_grnt), .wri_grnt(wri_grnt), .wrc_grnt(wrc_grnt),
    .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr),
    .bank_wr_en(bank_wr_en), .bank_wr_addr(bank_wr_addr), .bank_wr_word(bank_wr_word)
  );

  int checks = 0;
  int errors = 0;

  // Model state: consecutive denied cycles per requester, pending read tags.
  int         rcnt [3];
  int         wcnt [3];
  logic [2:0] vld_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester the rules select: a starved I, then a starved C, then
  // plain D > I > C. Returns -1 when nobody requests.
  function automatic int pick(input logic [2:0] en, input int ci, input int cc);
    if (en[1] && ci >= MAXWAIT) return 1;
    if (en[2] && cc >= MAXWAIT) return 2;
    for (int r = 0; r < 3; r++) if (en[r]) return r;
    return -1;
  endfunction

  function automatic int next_cnt(input logic en, input logic won, input int c);
    if (!en || won) return 0;
    return (c + 1 > MAXWAIT) ? MAXWAIT : c + 1;
  endfunction

  task automatic model_reset();
    rcnt = '{0, 0, 0};
    wcnt = '{0, 0, 0};
    vld_q.delete();
    repeat (RDLAT) vld_q.push_back(3'b000);
  endtask

  task automatic model_check();
    logic [2:0]   ren, wen, eg_r, eg_w, ev;
    logic [A-1:0] ra [3];
    logic [A-1:0] wa [3];
    logic [W-1:0] ww [3];
    logic [A-1:0] e_raddr, e_waddr;
    logic [W-1:0] e_wword;
    int gr, gw;
    ren = {rdc_en, rdi_en, rdd_en};
    wen = {wrc_en, wri_en, wrd_en};
    ra = '{rdd_addr, rdi_addr, rdc_addr};
    wa = '{wrd_addr, wri_addr, wrc_addr};
    ww = '{wrd_word, wri_word, wrc_word};
    eg_r = 3'b000; eg_w = 3'b000; ev = 3'b000;
    e_raddr = '0; e_waddr = '0; e_wword = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
      gr = pick(ren, rcnt[1], rcnt[2]);
      gw = pick(wen, wcnt[1], wcnt[2]);
      if (gr >= 0) begin eg_r = 3'b001 << gr; e_raddr = ra[gr]; end
      if (gw >= 0) begin eg_w = 3'b001 << gw; e_waddr = wa[gw]; e_wword = ww[gw]; end
      ev = vld_q.pop_front();
      vld_q.push_back(eg_r);
      for (int r = 1; r < 3; r++) begin
        rcnt[r] = next_cnt(ren[r], gr == r, rcnt[r]);
        wcnt[r] = next_cnt(wen[r], gw == r, wcnt[r]);
      end
    end
    chk("rd_grnt", {rdc_grnt, rdi_grnt, rdd_grnt}, eg_r);
    chk("wr_grnt", {wrc_grnt, wri_grnt, wrd_grnt}, eg_w);
    chk("rd_vld", {rdc_vld, rdi_vld, rdd_vld}, ev);
    chk("bank_rd_en", bank_rd_en, |eg_r);
    chk("bank_rd_addr", bank_rd_addr, e_raddr);
    chk("bank_wr_en", bank_wr_en, |eg_w);
    chk("bank_wr_addr", bank_wr_addr, e_waddr);
    chk("bank_wr_word", bank_wr_word, e_wword);
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    rdd_en = 1'b0; rdi_en = 1'b0; rdc_en = 1'b0;
    wrd_en = 1'b0; wri_en = 1'b0; wrc_en = 1'b0;
  endtask

  task automatic drain(input int n);
    idle_all();
    repeat (n) begin sample(); advance(); end
  endtask

  logic [2:0] vlds;
  assign vlds = {rdc_vld, rdi_vld, rdd_vld};

  initial begin
    idle_all();
    rdd_addr = '0; rdi_addr = '0; rdc_addr = '0;
    wrd_addr = '0; wri_addr = '0; wrc_addr = '0;
    wrd_word = '0; wri_word = '0; wrc_word = '0;
    model_reset();
    rst_n = 1'b0;

    // Reset state, with a request pending that must not be granted.
    rdd_en = 1'b1;
    sample();
    chk("reset_grnt", {rdc_grnt, rdi_grnt, rdd_grnt}, 3'b000);
    chk("reset_bank_en", {bank_rd_en, bank_wr_en}, 2'b00);
    chk("reset_vld", vlds, 3'b000);
    advance();
    rdd_en = 1'b0;
    sample(); advance();
    rst_n = 1'b1;

    // Single D read: same-cycle grant, one vld pulse exactly RDLAT later.
    rdd_en = 1'b1; rdd_addr = 15'h0010;
    sample();
    chk("t1_rdd_grnt", rdd_grnt, 1'b1);
    chk("t1_bank_rd_addr", bank_rd_addr, 15'h0010);
    advance();
    rdd_en = 1'b0;
    sample(); chk("t1_vld_early", vlds, 3'b000); advance();
    sample(); chk("t1_vld", vlds, 3'b001); advance();
    sample(); chk("t1_vld_once", vlds, 3'b000); advance();

    // All three readers held: D for 15 cycles, then I, then C, then D.
    rdd_en = 1'b1; rdi_en = 1'b1; rdc_en = 1'b1;
    rdd_addr = 15'h0001; rdi_addr = 15'h0002; rdc_addr = 15'h0003;
    for (int k = 0; k < 18; k++) begin
      sample();
      if (k < 15)  chk("t2_d_phase", {rdc_grnt, rdi_grnt, rdd_grnt}, 3'b001);
      if (k == 15) chk("t2_i_forced", {rdc_grnt, rdi_grnt, rdd_grnt}, 3'b010);
      if (k == 16) chk("t2_c_forced", {rdc_grnt, rdi_grnt, rdd_grnt}, 3'b100);
      if (k == 17) chk("t2_d_again", {rdc_grnt, rdi_grnt, rdd_grnt}, 3'b001);
      advance();
    end
    drain(4);

    // Writes from I and C alongside a D read.
    rdd_en = 1'b1; rdd_addr = 15'h0040;
    wri_en = 1'b1; wri_addr = 15'h0100; wri_word = 64'hA5A5_A5A5_A5A5_A5A5;
    wrc_en = 1'b1; wrc_addr = 15'h0200; wrc_word = 64'h5A5A_5A5A_0000_FFFF;
    sample();
    chk("t3_wr_grnt", {wrc_grnt, wri_grnt, wrd_grnt}, 3'b010);
    chk("t3_bank_wr_en", bank_wr_en, 1'b1);
    chk("t3_bank_wr_word", bank_wr_word, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t3_rdd_grnt", rdd_grnt, 1'b1);
    advance();
    rdd_en = 1'b0; wri_en = 1'b0;
    sample();
    chk("t3_wrc_grnt", {wrc_grnt, wri_grnt, wrd_grnt}, 3'b100);
    chk("t3_bank_wr_addr", bank_wr_addr, 15'h0200);
    advance();
    drain(4);

    // Alternating I/C reads: vld pulses follow in order, RDLAT cycles late.
    for (int j = 0; j < 8; j++) begin
      rdi_en = (j < 6) && (j % 2 == 0);
      rdc_en = (j < 6) && (j % 2 == 1);
      rdi_addr = A'($urandom); rdc_addr = A'($urandom);
      sample();
      if (j < 2) chk("t4_vld_pre", vlds, 3'b000);
      else       chk("t4_vld_seq", vlds, ((j - 2) % 2 == 0) ? 3'b010 : 3'b100);
      advance();
    end
    drain(3);

    // Reset pulse with two reads in flight: they must never return.
    rdd_en = 1'b1; sample(); advance();
    rdd_en = 1'b0; rdi_en = 1'b1; sample(); advance();
    rdi_en = 1'b0; rdd_en = 1'b1; rst_n = 1'b0;
    sample();
    chk("t5_grnt_in_reset", {rdc_grnt, rdi_grnt, rdd_grnt}, 3'b000);
    chk("t5_vld_in_reset", vlds, 3'b000);
    advance();
    rst_n = 1'b1; rdd_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      sample(); chk("t5_no_stale_vld", vlds, 3'b000); advance();
    end
    // Counters restarted from zero: I needs the full 15 denied cycles again.
    rdd_en = 1'b1; rdi_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      sample();
      if (k == 14) chk("t5_i_not_yet", rdi_grnt, 1'b0);
      if (k == 15) chk("t5_i_forced", rdi_grnt, 1'b1);
      advance();
    end
    drain(4);

    // rdi_en drops for one cycle at count 10: the wait restarts from zero.
    rdd_en = 1'b1;
    for (int k = 0; k < 27; k++) begin
      rdi_en = (k != 10);
      sample();
      if (k == 15) chk("t6_no_early_force", rdi_grnt, 1'b0);
      if (k == 25) chk("t6_i_not_yet", rdi_grnt, 1'b0);
      if (k == 26) chk("t6_i_forced", rdi_grnt, 1'b1);
      advance();
    end
    drain(4);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 3000; n++) begin
      rst_n  = ($urandom_range(0, 199) != 0);
      rdd_en = ($urandom_range(0, 3) != 0);
      rdi_en = ($urandom_range(0, 2) != 0);
      rdc_en = ($urandom_range(0, 2) != 0);
      wrd_en = ($urandom_range(0, 1) != 0);
      wri_en = ($urandom_range(0, 2) != 0);
      wrc_en = ($urandom_range(0, 2) != 0);
      rdd_addr = A'($urandom); rdi_addr = A'($urandom); rdc_addr = A'($urandom);
      wrd_addr = A'($urandom); wri_addr = A'($urandom); wrc_addr = A'($urandom);
      wrd_word = {$urandom, $urandom};
      wri_word = {$urandom, $urandom};
      wrc_word = {$urandom, $urandom};
      sample();
      advance();
    end
    rst_n = 1'b1;
    drain(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
